seq_det_ctrl: RTL and testbench

Programmable serial pattern-detection controller. It accepts a pattern configuration (bits, length, match target) through a valid/ready handshake. On command it runs a bit stream through a windowed comparator, counting overlapping matches until the target is reached or the run is aborted. It is the sequencing/configuration layer above the fixed-pattern serial detectors and replaces hard-coded detector FSMs with one configurable block.

---
 rtl/seq_det_pkg.sv | 10 +
 rtl/seq_det_window.sv | 37 +++
 rtl/seq_det_ctrl.sv | 90 +++++++++
 tb/tb_seq_det_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared FSM state encodings for the pattern detector
package seq_det_pkg;
  localparam int ST_W = 2;
  typedef enum logic [ST_W-1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/seq_det_window.sv
// seq_det_window: serial shift window, saturating fill counter and masked comparator
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             hit
);
  logic [PAT_W-1:0] win_q, win_d, mask;
  logic [LEN_W-1:0] fill_q, fill_d;
  // next window/fill, and a hit judged on the post-shift contents
  always_comb begin
    win_d = clear ? '0 : shift_en ? {win_q[PAT_W-2:0], bit_in} : win_q;
    fill_d = clear ? '0 : (shift_en && fill_q < len) ? fill_q + 1'b1 : fill_q;
    mask = '0;
    for (int i = 0; i < PAT_W; i++) mask[i] = i < int'(len);
    hit = shift_en && !clear && fill_d == len && ((win_d ^ pattern) & mask) == '0;
  end
  // window and fill registers
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
    end
  end
endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: configurable serial pattern-detection controller
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_target,
  output logic             cfg_err,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             bit_ready,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done,
  output logic [ST_W-1:0]  state
);
  state_t           state_q;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] tgt_q, cnt_q, cnt_d;
  logic             err_q, match_q;
  logic             cfg_ok, cfg_take, kill, go, shift_en, hit;
  assign cfg_ready = state_q != RUN;
  assign bit_ready = state_q == RUN;
  assign busy      = state_q == RUN;
  assign done      = state_q == DONE;
  assign state     = state_q;
  assign cfg_err   = err_q;
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign cfg_ok    = cfg_len != '0 && int'(cfg_len) <= PAT_W;
  assign cfg_take  = cfg_valid && cfg_ready;
  assign kill      = abort && (state_q == RUN || state_q == DONE);
  assign go        = start && !cfg_take && !kill && (state_q == ARMED || state_q == DONE);
  assign shift_en  = state_q == RUN && bit_valid && !abort;
  assign cnt_d     = &cnt_q ? cnt_q : cnt_q + 1'b1;

  seq_det_window #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_win (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .clear    (go),
    .bit_in   (bit_in),
    .pattern  (pat_q),
    .len      (len_q),
    .hit      (hit)
  );

  // FSM with config latch, match counter and registered pulses; abort beats cfg beats start
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      err_q   <= !kill && cfg_take && !cfg_ok;
      match_q <= hit;
      if (kill) state_q <= IDLE;
      else if (cfg_take) begin
        if (cfg_ok) begin
          pat_q   <= cfg_pattern;
          len_q   <= cfg_len;
          tgt_q   <= cfg_target;
          state_q <= ARMED;
        end
      end else if (go) begin
        cnt_q   <= '0;
        state_q <= RUN;
      end else if (hit) begin
        cnt_q <= cnt_d;
        if (tgt_q != '0 && cnt_d == tgt_q) state_q <= DONE;
      end
    end
  end
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: directed self-checking bench for seq_det_ctrl
module tb_seq_det_ctrl;
  logic       clk = 1'b0;
  logic       rst, cfg_valid, start, abort, bit_valid, bit_in;
  logic [7:0] cfg_pattern, cfg_target;
  logic [3:0] cfg_len;
  logic       cfg_ready, cfg_err, bit_ready, match, busy, done;
  logic [7:0] match_cnt;
  logic [1:0] state;
  int checks = 0;
  int errors = 0;

  seq_det_ctrl #(.PAT_W(8), .LEN_W(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_target  (cfg_target),
    .cfg_err     (cfg_err),
    .start       (start),
    .abort       (abort),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .bit_ready   (bit_ready),
    .match       (match),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .done        (done),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t);
    cfg_valid = 1'b1; cfg_pattern = p; cfg_len = l; cfg_target = t;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic b);
    bit_valid = 1'b1; bit_in = b;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 0; start = 0; abort = 0; bit_valid = 0; bit_in = 0;
    cfg_pattern = '0; cfg_len = '0; cfg_target = '0;
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_bit_ready", bit_ready, 0);
    chk("rst_match", match, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cfg_err, 0);
    rst = 1'b0;
    // 101011, len 6, target 1
    cfg(8'b0010_1011, 4'd6, 8'd1);
    chk("t1_armed", state, 1);
    run();
    chk("t1_run", state, 2);
    chk("t1_busy", busy, 1);
    chk("t1_cfg_ready", cfg_ready, 0);
    send(1); send(0); send(1); send(0); send(1);
    chk("t1_nomatch5", match, 0);
    send(1);
    chk("t1_match", match, 1);
    chk("t1_cnt", match_cnt, 1);
    chk("t1_done_state", state, 3);
    chk("t1_bit_ready", bit_ready, 0);
    chk("t1_done", done, 1);
    tick();
    chk("t1_match_pulse", match, 0);
    // 101, len 3, unlimited, overlapping
    cfg(8'b101, 4'd3, 8'd0);
    chk("t2_armed", state, 1);
    run();
    send(1); send(0);
    chk("t2_nomatch2", match, 0);
    send(1);
    chk("t2_match3", match, 1);
    send(0);
    chk("t2_nomatch4", match, 0);
    send(1);
    chk("t2_match5", match, 1);
    chk("t2_cnt", match_cnt, 2);
    chk("t2_still_run", state, 2);
    do_abort();
    chk("t2_abort_idle", state, 0);
    chk("t2_abort_cnt", match_cnt, 2);
    // 000 fill guard
    cfg(8'b000, 4'd3, 8'd0);
    run();
    chk("t3_cnt_clr", match_cnt, 0);
    send(0);
    chk("t3_nomatch1", match, 0);
    send(0);
    chk("t3_nomatch2", match, 0);
    send(0);
    chk("t3_match3", match, 1);
    chk("t3_cnt", match_cnt, 1);
    do_abort();
    // 11, len 2, target 2
    cfg(8'b11, 4'd2, 8'd2);
    run();
    send(1);
    chk("t4_nomatch1", match, 0);
    send(1);
    chk("t4_match2", match, 1);
    chk("t4_cnt2", match_cnt, 1);
    chk("t4_run", state, 2);
    send(1);
    chk("t4_match3", match, 1);
    chk("t4_cnt3", match_cnt, 2);
    chk("t4_done", state, 3);
    send(1);
    chk("t4_no4", match, 0);
    chk("t4_cnt4", match_cnt, 2);
    chk("t4_hold_done", state, 3);
    // illegal lengths and ignored start in IDLE
    do_abort();
    chk("t5_idle", state, 0);
    cfg(8'hff, 4'd0, 8'd1);
    chk("t5_err0", cfg_err, 1);
    chk("t5_state0", state, 0);
    tick();
    chk("t5_err_pulse", cfg_err, 0);
    cfg(8'hff, 4'd9, 8'd1);
    chk("t5_err9", cfg_err, 1);
    chk("t5_state9", state, 0);
    run();
    chk("t5_start_ignored", state, 0);
    chk("t5_err_clear", cfg_err, 0);
    // reset mid-run
    cfg(8'b101, 4'd3, 8'd0);
    run();
    send(1); send(0);
    rst = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    rst = 1'b0; bit_valid = 1'b0;
    chk("t6_state", state, 0);
    chk("t6_cfg_ready", cfg_ready, 1);
    chk("t6_bit_ready", bit_ready, 0);
    chk("t6_match", match, 0);
    chk("t6_cnt", match_cnt, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    cfg(8'b11, 4'd2, 8'd1);
    run();
    send(1);
    chk("t6_nomatch", match, 0);
    send(1);
    chk("t6_match", match, 1);
    chk("t6_final", state, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
